// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters,
// combinational fetch-PC lookup, registered training and saturating hit/miss statistics.
module branch_target_predictor #(
    parameter int ENTRIES  = 64,
    parameter int IDX_BITS = 6,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pcF,
    output logic             pred_taken,
    output logic [31:0]      pred_pc,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic [31:0]      upd_target,
    input  logic             upd_taken,
    input  logic             bp_success,
    input  logic             bp_failure,
    output logic [CNT_W-1:0] stat_success,
    output logic [CNT_W-1:0] stat_failure
);

    localparam int TAG_W = 32 - IDX_BITS - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];

    logic [CNT_W-1:0]   stat_success_q, stat_success_d;
    logic [CNT_W-1:0]   stat_failure_q, stat_failure_d;

    logic [IDX_BITS-1:0] idx_s;
    logic                hit_s;
    logic [IDX_BITS-1:0] u_idx_s;
    logic [TAG_W-1:0]    u_tag_s;
    logic                u_hit_s;
    logic [1:0]          ctr_d;
    logic                ctr_wr_s;
    logic                alloc_s;
    logic                tgt_wr_s;

    // Byte-offset bits of both PCs carry no information for a word-aligned fetch.
    logic unused_s;
    assign unused_s = ^{pcF[1:0], upd_pc[1:0]};

    // Zero-latency lookup of the fetch PC; forced to fall-through while reset is held.
    always_comb begin
        idx_s      = pcF[IDX_BITS+1:2];
        hit_s      = valid_q[idx_s] && (tag_q[idx_s] == pcF[31:IDX_BITS+2]);
        pred_taken = 1'b0;
        if (rst) begin
            pred_taken = 1'b0;
        end else begin
            pred_taken = hit_s & ctr_q[idx_s][1];
        end
        pred_pc = pred_taken ? target_q[idx_s] : (pcF + 32'd4);
    end

    // Training decode: strengthen/weaken on a hit, allocate on a taken miss.
    always_comb begin
        u_idx_s  = upd_pc[IDX_BITS+1:2];
        u_tag_s  = upd_pc[31:IDX_BITS+2];
        u_hit_s  = valid_q[u_idx_s] && (tag_q[u_idx_s] == u_tag_s);
        ctr_d    = ctr_q[u_idx_s];
        ctr_wr_s = 1'b0;
        alloc_s  = 1'b0;
        tgt_wr_s = 1'b0;
        if (upd_valid && !rst) begin
            if (u_hit_s) begin
                ctr_wr_s = 1'b1;
                if (upd_taken) begin
                    tgt_wr_s = 1'b1;
                    ctr_d    = (ctr_q[u_idx_s] == 2'b11) ? 2'b11 : (ctr_q[u_idx_s] + 2'd1);
                end else begin
                    ctr_d    = (ctr_q[u_idx_s] == 2'b00) ? 2'b00 : (ctr_q[u_idx_s] - 2'd1);
                end
            end else if (upd_taken) begin
                ctr_wr_s = 1'b1;
                alloc_s  = 1'b1;
                tgt_wr_s = 1'b1;
                ctr_d    = 2'b10;
            end else begin
                ctr_wr_s = 1'b0;
            end
        end else begin
            ctr_wr_s = 1'b0;
        end
    end

    // Saturating next values for the performance counters.
    always_comb begin
        stat_success_d = stat_success_q;
        stat_failure_d = stat_failure_q;
        if (bp_success && (stat_success_q != {CNT_W{1'b1}})) begin
            stat_success_d = stat_success_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stat_success_d = stat_success_q;
        end
        if (bp_failure && (stat_failure_q != {CNT_W{1'b1}})) begin
            stat_failure_d = stat_failure_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stat_failure_d = stat_failure_q;
        end
    end

    // Reset-cleared state: valid bits, direction counters and statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q        <= {ENTRIES{1'b0}};
            stat_success_q <= {CNT_W{1'b0}};
            stat_failure_q <= {CNT_W{1'b0}};
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else begin
            if (ctr_wr_s) begin
                ctr_q[u_idx_s] <= ctr_d;
            end
            if (alloc_s) begin
                valid_q[u_idx_s] <= 1'b1;
            end
            stat_success_q <= stat_success_d;
            stat_failure_q <= stat_failure_d;
        end
    end

    // Tag and target payload; meaningless until the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (alloc_s) begin
            tag_q[u_idx_s] <= u_tag_s;
        end
        if (tgt_wr_s) begin
            target_q[u_idx_s] <= upd_target;
        end
    end

    assign stat_success = stat_success_q;
    assign stat_failure = stat_failure_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench: directed vector table, counter/reset sequences, and a
// randomized run against an array-based behavioural model of the predictor.
module tb_branch_target_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcF;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        bp_success;
    logic        bp_failure;

    logic        pred_taken;
    logic [31:0] pred_pc;
    logic [31:0] stat_success;
    logic [31:0] stat_failure;

    logic        s_pred_taken;
    logic [31:0] s_pred_pc;
    logic [3:0]  s_stat_success;
    logic [3:0]  s_stat_failure;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_target_predictor #(.ENTRIES(64), .IDX_BITS(6), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .pcF(pcF), .pred_taken(pred_taken), .pred_pc(pred_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .bp_success(bp_success), .bp_failure(bp_failure),
        .stat_success(stat_success), .stat_failure(stat_failure)
    );

    branch_target_predictor #(.ENTRIES(64), .IDX_BITS(6), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .pcF(pcF), .pred_taken(s_pred_taken), .pred_pc(s_pred_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .bp_success(bp_success), .bp_failure(bp_failure),
        .stat_success(s_stat_success), .stat_failure(s_stat_failure)
    );

    // Behavioural model: plain arrays indexed by word address modulo 64.
    bit          m_valid  [64];
    int unsigned m_tag    [64];
    int unsigned m_target [64];
    int          m_ctr    [64];
    longint      m_succ, m_fail;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_succ = 0;
        m_fail = 0;
    endtask

    function automatic int unsigned model_pred(input int unsigned pc);
        int unsigned e = (pc / 4) % 64;
        if (m_valid[e] && m_tag[e] == pc / 256 && m_ctr[e] >= 2) return m_target[e];
        return pc + 4;
    endfunction

    task automatic model_edge();
        int unsigned e = (upd_pc / 4) % 64;
        bit hit = m_valid[e] && (m_tag[e] == upd_pc / 256);
        if (upd_valid) begin
            if (hit && upd_taken) begin
                m_ctr[e] = (m_ctr[e] < 3) ? m_ctr[e] + 1 : 3;
                m_target[e] = upd_target;
            end else if (hit) begin
                m_ctr[e] = (m_ctr[e] > 0) ? m_ctr[e] - 1 : 0;
            end else if (upd_taken) begin
                m_valid[e]  = 1'b1;
                m_tag[e]    = upd_pc / 256;
                m_target[e] = upd_target;
                m_ctr[e]    = 2;
            end
        end
        if (bp_success) m_succ++;
        if (bp_failure) m_fail++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        upd_valid  = 1'b0;
        upd_pc     = 32'h0;
        upd_target = 32'h0;
        upd_taken  = 1'b0;
        bp_success = 1'b0;
        bp_failure = 1'b0;
    endtask

    typedef struct {
        logic [31:0] look;
        logic        uv;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic        utk;
        logic        exp_tk;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vt[16];

    initial begin
        // Each row: lookup checked in this cycle (pre-update), update applied at the next edge.
        vt[0]  = '{32'h100, 1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 32'h104};
        vt[1]  = '{32'h100, 1'b1, 32'h100, 32'h0,   1'b0, 1'b1, 32'h200};
        vt[2]  = '{32'h100, 1'b1, 32'h100, 32'h0,   1'b0, 1'b0, 32'h104};
        vt[3]  = '{32'h100, 1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 32'h104};
        vt[4]  = '{32'h100, 1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 32'h104};
        vt[5]  = '{32'h100, 1'b1, 32'h100, 32'h200, 1'b1, 1'b1, 32'h200};
        vt[6]  = '{32'h100, 1'b1, 32'h100, 32'h200, 1'b1, 1'b1, 32'h200};
        vt[7]  = '{32'h100, 1'b1, 32'h100, 32'h0,   1'b0, 1'b1, 32'h200};
        vt[8]  = '{32'h100, 1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 32'h200};
        vt[9]  = '{32'h100, 1'b1, 32'h200, 32'h300, 1'b1, 1'b1, 32'h200};
        vt[10] = '{32'h100, 1'b1, 32'h400, 32'h999, 1'b0, 1'b0, 32'h104};
        vt[11] = '{32'h200, 1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 32'h300};
        vt[12] = '{32'h400, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h404};
        vt[13] = '{32'h203, 1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 32'h300};
        vt[14] = '{32'h200, 1'b1, 32'h201, 32'h500, 1'b1, 1'b1, 32'h300};
        vt[15] = '{32'h200, 1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 32'h500};

        rst = 1'b1;
        pcF = 32'h100;
        idle_inputs();
        upd_valid = 1'b1; upd_pc = 32'h100; upd_target = 32'h200; upd_taken = 1'b1;
        tick();
        tick();
        chk("rst_pred_taken", {31'b0, pred_taken}, 32'h0);
        chk("rst_pred_pc", pred_pc, 32'h104);
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_taken", {31'b0, pred_taken}, 32'h0);
        chk("post_rst_pc", pred_pc, 32'h104);
        chk("post_rst_succ", stat_success, 32'h0);
        chk("post_rst_fail", stat_failure, 32'h0);

        tick();
        for (int i = 0; i < 16; i++) begin
            pcF = vt[i].look;
            upd_valid = vt[i].uv; upd_pc = vt[i].upc;
            upd_target = vt[i].utgt; upd_taken = vt[i].utk;
            #2;
            chk($sformatf("vec%0d_taken", i), {31'b0, pred_taken}, {31'b0, vt[i].exp_tk});
            chk($sformatf("vec%0d_pc", i), pred_pc, vt[i].exp_pc);
            tick();
        end
        idle_inputs();

        // Counter sequence: 5 successes, 3 failures, one cycle with both.
        for (int i = 0; i < 7; i++) begin
            bp_success = (i < 5);
            bp_failure = (i == 0) || (i >= 5);
            tick();
        end
        idle_inputs();
        chk("stat_succ_5", stat_success, 32'd5);
        chk("stat_fail_3", stat_failure, 32'd3);
        chk("small_succ_5", {28'b0, s_stat_success}, 32'd5);
        for (int i = 0; i < 12; i++) begin
            bp_success = 1'b1;
            tick();
        end
        idle_inputs();
        chk("stat_succ_17", stat_success, 32'd17);
        chk("small_succ_sat", {28'b0, s_stat_success}, 32'd15);
        bp_success = 1'b1;
        tick();
        chk("small_succ_hold", {28'b0, s_stat_success}, 32'd15);

        // Mid-operation reset with a taken update pending: asynchronous clear, update dropped.
        pcF = 32'h200;
        upd_valid = 1'b1; upd_pc = 32'h300; upd_target = 32'h700; upd_taken = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_succ", stat_success, 32'h0);
        chk("async_rst_fail", stat_failure, 32'h0);
        chk("async_rst_pc", pred_pc, 32'h204);
        tick();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        pcF = 32'h300;
        #1;
        chk("rst_drop_upd_pc", pred_pc, 32'h304);
        chk("rst_drop_succ", stat_success, 32'h0);

        // Randomized phase against the model; PCs drawn from a small pool to force hits and aliases.
        model_reset();
        tick();
        for (int n = 0; n < 3000; n++) begin
            pcF        = {22'b0, $urandom_range(3, 0) << 8} | ($urandom_range(3, 0) << 2) | $urandom_range(3, 0);
            upd_valid  = ($urandom_range(3, 0) != 0);
            upd_pc     = {22'b0, $urandom_range(3, 0) << 8} | ($urandom_range(3, 0) << 2) | $urandom_range(3, 0);
            upd_target = $urandom & 32'hFFFF_FFFC;
            upd_taken  = $urandom_range(1, 0);
            bp_success = ($urandom_range(2, 0) == 0);
            bp_failure = ($urandom_range(2, 0) == 0);
            #2;
            checks++;
            if (pred_pc !== model_pred(pcF) || pred_taken !== (model_pred(pcF) != pcF + 4)
                || stat_success !== m_succ[31:0] || stat_failure !== m_fail[31:0]
                || s_stat_success !== 4'((m_succ > 15) ? 15 : m_succ)
                || s_stat_failure !== 4'((m_fail > 15) ? 15 : m_fail)) begin
                failures++;
                $display("FAIL rand%0d: pcF=0x%08h got pc=0x%08h tk=%0b succ=%0d fail=%0d s=%0d/%0d expected pc=0x%08h succ=%0d fail=%0d",
                         n, pcF, pred_pc, pred_taken, stat_success, stat_failure, s_stat_success, s_stat_failure,
                         model_pred(pcF), m_succ, m_fail);
            end
            model_edge();
            tick();
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
Fetch-stage branch predictor. It is a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Each cycle it looks up the fetch PC and supplies the predicted next PC to the fetch mux.
- It is trained by the resolved branch outcome from decode/execute.
- It counts prediction successes and failures reported by the decode-stage prediction checker, for performance monitoring.
- It sits directly upstream of that checker: this block's predicted PC becomes the pcD that the checker compares.

Parameters:
ENTRIES, 64, number of BTB entries; must be a power of two, minimum 4.
IDX_BITS, 6, log2(ENTRIES); index field is pc[IDX_BITS+1:2].
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  asynchronous reset, active-high.
pcF  in  32  current fetch PC.
pred_taken  out  1  prediction that pcF is a taken branch.
pred_pc  out  32  predicted next fetch PC.
upd_valid  in  1  resolved-branch update strobe, one cycle per resolved branch.
upd_pc  in  32  PC of the resolved branch.
upd_target  in  32  resolved taken target.
upd_taken  in  1  resolved direction; 1 = taken.
bp_success  in  1  decode-stage checker reports a correct prediction.
bp_failure  in  1  decode-stage checker reports a misprediction.
stat_success  out  CNT_W  count of success pulses.
stat_failure  out  CNT_W  count of failure pulses.

Behaviour:
- Storage per entry: valid bit, tag = pc[31:IDX_BITS+2], target[31:0], 2-bit counter ctr.
- Reset (asynchronous) clears:
  - all valid bits to 0;
  - all ctr to 2'b01 (weakly not-taken);
  - stat_success and stat_failure to 0.
  - Tag and target contents need not be reset.
- Lookup is combinational, zero latency:
  - idx = pcF[IDX_BITS+1:2].
  - hit = valid[idx] & (tag[idx] == pcF[31:IDX_BITS+2]).
  - pred_taken = hit & ctr[idx][1].
  - pred_pc = pred_taken ? target[idx] : pcF + 4.
- Lookup behaviour during and after reset:
  - While rst is asserted, pred_taken = 0 and pred_pc = pcF + 4.
  - Immediately after reset, every lookup misses.
- Update is registered; it applies at the rising edge where upd_valid = 1. With u = upd_pc[IDX_BITS+1:2], the cases are:
  - Hit, taken: ctr increments, saturating at 2'b11; target[u] <= upd_target.
  - Hit, not-taken: ctr decrements, saturating at 2'b00; target is unchanged.
  - Miss, taken (including a tag conflict): allocate. valid <= 1, tag <= upd_pc tag, target <= upd_target, ctr <= 2'b10 (weakly taken). Any old entry is replaced.
  - Miss, not-taken: no state change.
- Simultaneous lookup and update to the same index in one cycle:
  - The lookup sees the pre-update contents; there is no bypass.
  - The new state is visible from the next cycle.
- upd_pc[1:0] and pcF[1:0] are ignored.
- Index wrap: PCs that differ only above bit IDX_BITS+1 alias to the same entry and are distinguished by the tag only.
- Performance counters:
  - stat_success increments by 1 on each edge with bp_success = 1.
  - stat_failure increments by 1 on each edge with bp_failure = 1.
  - Both saturate at all-ones and do not wrap.
  - If bp_success and bp_failure are asserted together, both counters increment. The checker never does this; the behaviour is still defined.
- Reset asserted mid-operation:
  - State clears immediately.
  - An update presented in the same cycle is discarded.
- No stall input: the fetch stage holds pcF stable during stalls, so the lookup output stays stable. Updates are never gated.

Test Plan:
1. Reset, then pcF = 0x0000_0100 -> pred_taken = 0, pred_pc = 0x0000_0104; stat_success = stat_failure = 0.
2. Update pc = 0x100, target = 0x200, taken = 1; next cycle pcF = 0x100 -> pred_taken = 1, pred_pc = 0x200 (ctr = 10).
3. From step 2, apply two not-taken updates at pc = 0x100 -> ctr goes 10 → 01 → 00; pcF = 0x100 gives pred_pc = 0x104. Three more taken updates -> ctr goes 01 → 10 → 11 and stays at 11; pred_pc = 0x200.
4. Alias: with ENTRIES = 64, entry at 0x100 allocated, then a taken update at pc = 0x200 (same idx 0) with target 0x300:
   - pcF = 0x100 -> miss, pred_pc = 0x104;
   - pcF = 0x200 -> pred_pc = 0x300.
   - Not-taken update at pc = 0x400 (miss) -> no change.
5. Same-cycle: pcF = 0x100 with allocate update at 0x100 in the same cycle -> that cycle pred_pc = 0x104; next cycle pred_pc = target.
6. Pulse bp_success 5 times and bp_failure 3 times (one cycle both high) -> stat_success = 5, stat_failure = 3. Preload a counter to all-ones via forced CNT_W = 4 and pulse again -> it holds at 15. Assert rst mid-sequence -> counters read 0 asynchronously.
